// File: rtl/mem_xfer_pkg.sv
// ============================================================================
// Module  : mem_xfer_pkg
// Purpose : Shared state encoding and width defaults for the transfer sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_xfer_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int ADDR_W_DEF    = 3;
    localparam int SRC_DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        LD0  = 3'd2,
        RD   = 3'd3,
        LD   = 3'd4,
        CMP  = 3'd5,
        DONE = 3'd6
    } xfer_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_xfer_ctrl_pair_reg.sv
// ============================================================================
// Module  : xfer_pair_reg
// Purpose : Older/newer word pair presented to the external comparator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module xfer_pair_reg #(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] older_o,
    output logic [DATA_W-1:0] newer_o
);

    logic [DATA_W-1:0] older_q;
    logic [DATA_W-1:0] newer_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            older_q <= '0;
            newer_q <= '0;
        end else if (shift_i) begin
            older_q <= newer_q;
            newer_q <= din_i;
        end else if (load_i) begin
            newer_q <= din_i;
        end
    end

    assign older_o = older_q;
    assign newer_o = newer_q;

endmodule

`default_nettype wire

// File: rtl/mem_xfer_ctrl.sv
// ============================================================================
// Module  : mem_xfer_ctrl
// Purpose : Reads memory A pairwise, feeds the comparator, routes words to B/C.
//           Optional build macro: MEMXFER_ABSDIFF_EN (write |DOut2-DOut1|).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_xfer_ctrl
    import mem_xfer_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SRC_DEPTH = SRC_DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] AddrA,
    output logic              ReadA,
    input  logic [DATA_W-1:0] DataA,
    output logic [DATA_W-1:0] DOut1,
    output logic [DATA_W-1:0] DOut2,
    input  logic              Sign,
    output logic [ADDR_W-1:0] AddrB,
    output logic              WeB,
    output logic [ADDR_W-1:0] AddrC,
    output logic              WeC,
    output logic [DATA_W-1:0] WData,
    output logic [ADDR_W-1:0] CountB,
    output logic [ADDR_W-1:0] CountC
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SRC_DEPTH - 1);

    xfer_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] cnt_b_q, cnt_c_q;
    logic [ADDR_W-1:0] addr_b_q, addr_c_q;
    logic              we_b_q, we_c_q;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = RD0;
            RD0:     state_d = LD0;
            LD0:     state_d = RD;
            RD:      state_d = LD;
            LD:      state_d = CMP;
            CMP:     state_d = (idx_q == LAST_IDX) ? DONE : RD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy  = (state_q != IDLE);
        Done  = (state_q == DONE);
        ReadA = (state_q == RD0) || (state_q == RD);
    end

    xfer_pair_reg #(.DATA_W(DATA_W)) u_pair (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load_i  (state_q == LD0),
        .shift_i (state_q == LD),
        .din_i   (DataA),
        .older_o (DOut1),
        .newer_o (DOut2)
    );

    // Sign picks the subtraction direction so the difference never wraps.
    always_comb begin
`ifdef MEMXFER_ABSDIFF_EN
        wdata_d = Sign ? (DOut1 - DOut2) : (DOut2 - DOut1);
`else
        wdata_d = DOut2;
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q    <= '0;
            cnt_b_q  <= '0;
            cnt_c_q  <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            we_b_q   <= 1'b0;
            we_c_q   <= 1'b0;
            wdata_q  <= '0;
        end else begin
            we_b_q <= 1'b0;
            we_c_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        idx_q   <= '0;
                        cnt_b_q <= '0;
                        cnt_c_q <= '0;
                    end
                end
                LD0: idx_q <= ADDR_W'(1);
                CMP: begin
                    wdata_q <= wdata_d;
                    if (Sign) begin
                        we_c_q   <= 1'b1;
                        addr_c_q <= cnt_c_q;
                        cnt_c_q  <= cnt_c_q + 1'b1;
                    end else begin
                        we_b_q   <= 1'b1;
                        addr_b_q <= cnt_b_q;
                        cnt_b_q  <= cnt_b_q + 1'b1;
                    end
                    if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // idx_q is the read index: 0 in RD0, i in RD, and holds afterwards.
    assign AddrA  = idx_q;
    assign AddrB  = addr_b_q;
    assign AddrC  = addr_c_q;
    assign WeB    = we_b_q;
    assign WeC    = we_c_q;
    assign WData  = wdata_q;
    assign CountB = cnt_b_q;
    assign CountC = cnt_c_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_xfer_ctrl.sv
// ============================================================================
// Module  : tb_mem_xfer_ctrl
// Purpose : Self-checking bench for mem_xfer_ctrl with a pairwise reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_xfer_ctrl;

    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, read_a, sign, we_b, we_c;
    logic [AW-1:0] addr_a, addr_b, addr_c, count_b, count_c;
    logic [DW-1:0] data_a = '0;
    logic [DW-1:0] dout1, dout2, wdata;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] got_b [$];
    logic [DW-1:0] got_c [$];
    logic [DW-1:0] exp_b [$];
    logic [DW-1:0] exp_c [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_xfer_ctrl #(.DATA_W(DW), .SRC_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .Clk(clk), .Reset_n(rst_n), .Start(start), .Busy(busy), .Done(done),
        .AddrA(addr_a), .ReadA(read_a), .DataA(data_a),
        .DOut1(dout1), .DOut2(dout2), .Sign(sign),
        .AddrB(addr_b), .WeB(we_b), .AddrC(addr_c), .WeC(we_c),
        .WData(wdata), .CountB(count_b), .CountC(count_c)
    );

    // Memory A with one-cycle read latency, and an unsigned comparator.
    always @(posedge clk) if (read_a) data_a <= mem_a[addr_a];
    assign sign = (dout2 < dout1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writes to B and C as seen by the destination memories.
    always @(negedge clk) begin
        if (rst_n) begin
            if (we_b && we_c) chk("both_strobes", 32'(we_b & we_c), 32'd0);
            if (we_b) begin
                chk("addr_b_seq", 32'(addr_b), 32'(got_b.size()));
                got_b.push_back(wdata);
            end
            if (we_c) begin
                chk("addr_c_seq", 32'(addr_c), 32'(got_c.size()));
                got_c.push_back(wdata);
            end
        end
    end

    task automatic build_exp();
        exp_b.delete();
        exp_c.delete();
        for (int k = 1; k < DEPTH; k++) begin
`ifdef MEMXFER_ABSDIFF_EN
            if (mem_a[k] < mem_a[k-1]) exp_c.push_back(mem_a[k-1] - mem_a[k]);
            else                       exp_b.push_back(mem_a[k] - mem_a[k-1]);
`else
            if (mem_a[k] < mem_a[k-1]) exp_c.push_back(mem_a[k]);
            else                       exp_b.push_back(mem_a[k]);
`endif
        end
    endtask

    // Entered at the negedge of cycle 1 of a transfer.
    task automatic finish_and_check(input int pulse_at);
        int cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_at);
        end
        start = 1'b0;
        chk("done_cycle", 32'(cyc), 32'(3 * DEPTH));
        chk("done_busy", 32'(busy), 32'd1);
        chk("last_strobe_with_done", 32'(we_b | we_c), 32'd1);
        chk("count_b", 32'(count_b), 32'(exp_b.size()));
        chk("count_c", 32'(count_c), 32'(exp_c.size()));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_strobes", 32'({we_b, we_c, read_a}), 32'd0);
        chk("n_b", 32'(got_b.size()), 32'(exp_b.size()));
        chk("n_c", 32'(got_c.size()), 32'(exp_c.size()));
        for (int k = 0; k < exp_b.size() && k < got_b.size(); k++) chk("data_b", 32'(got_b[k]), 32'(exp_b[k]));
        for (int k = 0; k < exp_c.size() && k < got_c.size(); k++) chk("data_c", 32'(got_c[k]), 32'(exp_c[k]));
    endtask

    task automatic run_xfer(input int pulse_at);
        build_exp();
        got_b.delete();
        got_c.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        finish_and_check(pulse_at);
    endtask

    initial begin
        logic [DW-1:0] t1 [DEPTH] = '{8'd1, 8'd3, 8'd2, 8'd2, 8'd5, 8'd0, 8'd7, 8'd4};

        #1;
        chk("rst_outputs", 32'({busy, done, read_a, we_b, we_c}), 32'd0);
        chk("rst_data", 32'({dout1, dout2, wdata}), 32'd0);
        chk("rst_addr", 32'({addr_a, addr_b, addr_c, count_b, count_c}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < DEPTH; k++) mem_a[k] = t1[k];
        run_xfer(0);

        for (int k = 0; k < DEPTH; k++) mem_a[k] = 8'hFF;
        run_xfer(0);

        for (int k = 0; k < DEPTH; k++) mem_a[k] = 8'(DEPTH - k);
        run_xfer(0);

        repeat (4) @(negedge clk);
        chk("count_b_hold", 32'(count_b), 32'd0);
        chk("count_c_hold", 32'(count_c), 32'(DEPTH - 1));

        // Start pulses while busy must not disturb the running transfer.
        for (int k = 0; k < DEPTH; k++) mem_a[k] = t1[k];
        run_xfer(7);
        run_xfer(14);

        // Reset in the middle of the third CMP (cycle 11).
        got_b.delete();
        got_c.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 32'({busy, done, read_a, we_b, we_c}), 32'd0);
        chk("arst_data", 32'({dout1, dout2, wdata}), 32'd0);
        chk("arst_addr", 32'({addr_a, addr_b, addr_c, count_b, count_c}), 32'd0);
        chk("arst_writes_before", 32'(got_b.size() + got_c.size()), 32'd2);
        repeat (3) @(negedge clk);
        chk("arst_no_more_writes", 32'(got_b.size() + got_c.size()), 32'd2);
        chk("arst_idle", 32'({busy, we_b, we_c}), 32'd0);
        #2 rst_n = 1'b1;
        run_xfer(0);

        // Start held high: exactly one IDLE cycle between transfers.
        build_exp();
        got_b.delete();
        got_c.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        begin
            int cyc = 1;
            while (!done && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("b2b_done_cycle", 32'(cyc), 32'(3 * DEPTH));
        end
        @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("b2b_restart", 32'(busy), 32'd1);
        start = 1'b0;
        got_b.delete();
        got_c.delete();
        finish_and_check(0);

        // Randomized source contents; narrow range exercises equal words.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < DEPTH; k++)
                mem_a[k] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            run_xfer((r % 3 == 0) ? int'($urandom_range(2, 20)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
